fsm_datapath: RTL and testbench
===============================

# fsm_datapath

Register-transfer datapath driven by the team's multi-cycle control FSM. It executes the control word (operand selects m0/m1, operation select m2, register loads lx/ls/lh, halve h, done) issued each clock. It returns status flags and a captured result to the controller and host. It is the execution end of the controller's control-word interface.

## Interface
- W, default 8: data width of X, S, H, data_in and result.
- CW, default 16: width of op_count (saturating).

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset rst, synchronous, active-high; clock clk
- data_in  input  W  external operand, used when an operand select = 2'b11 (m0) 
- m0  input  2  operand A select: 00 X, 01 S, 10 H, 11 data_in
- m1  input  2  operand B select: 00 X, 01 S, 10 H, 11 constant 1
- m2  input  2  operation: 00 A+B, 01 A−B, 10 pass A, 11 A<<1
- lx / ls / lh  input  1 each  load ALU write value into X / S / H
- h  input  1  halve: write value = {carry, raw[W-1:1]}
- done  input  1  capture S into result, end of job
- x_q, s_q, h_q  output  W each  register contents
- flag_z, flag_n, flag_c  output  1 each  zero, negative (msb), carry/borrow of last write
- result  output  W  captured result
- result_valid  output  1  one-cycle pulse after done
- op_count  output  CW  number of load cycles in the last completed job

## Operation
- ALU is combinational, W+1 bits: add → {c, raw} = A+B; sub → {c, raw} = A−B, c = 1 on borrow (A<B unsigned); pass → raw = A, c = 0; shl → {c, raw} = {A, 1'b0}.
- Write value wv = h ? {c, raw[W-1:1]} : raw. When h=1, flags are computed from wv; flag_c still reports c.
- Load cycle = any of lx, ls, lh high. Every asserted load writes wv to its register. Multiple simultaneous loads all write the same wv.
- Flags update only on load cycles: z = (wv==0), n = wv[W-1], c as above. They hold otherwise.
- Job counter: an internal count increments on each load cycle, saturating at 2^CW−1.
- On done: result ← next value of S. If ls is high in the same cycle, that is the new wv; otherwise it is s_q. op_count ← internal count, including the current cycle if it is a load cycle. The internal count clears to 0.
- result_valid is high for exactly the cycle after done is sampled. Back-to-back done produces back-to-back pulses.
- Control inputs are never illegal. All 2-bit codes are defined, and an all-zero control word is a no-op hold.

## Timing
- Reset: x_q, s_q, h_q, result, op_count, internal count = 0. flag_z = 0, flag_n = 0, flag_c = 0. result_valid = 0.
- rst has priority over every control input in the same cycle. Reset mid-job discards all state, and no result_valid pulse follows.
- Register update latency: 1 cycle. Values are visible on x_q/s_q/h_q and flags after the edge that samples the load.
- Result latency: result and op_count are valid, and result_valid is high, in the cycle following the edge that samples done. result and op_count hold until the next done.
- Operand reads use pre-edge register values. For example, X ← X+X with lx reads the old X.
- Wrap-around: add/shl overflow is truncated to W bits with c=1. Sub wraps modulo 2^W.

## Test plan
- Reset: assert rst 2 cycles with random control inputs → all outputs 0, result_valid never high.
- Load/increment: data_in=0x05, m0=11, m2=10, lx=1 → x_q=0x05, z=0. Then m0=00, m1=11, m2=00, ls=1 → s_q=0x06, flags z0 n0 c0.
- Halved add: X=0xFF, H=0x01, m0=00, m1=10, m2=00, h=1, lh=1 → h_q=0x80, c=1, n=1, z=0.
- Borrow and shift: S=0x06, X=0x07, m0=01, m1=00, m2=01, ls=1 → s_q=0xFF, c=1, n=1. Then m0=01, m2=11, ls=1 → s_q=0xFE, c=1.
- Done with same-cycle ls: 3 load cycles, then a cycle with ls=1 and done=1 writing 0x2A → next cycle result=0x2A, op_count=4, result_valid=1 for one cycle. The following done with no loads → op_count=0.
- Reset mid-job: 2 load cycles, then rst in the cycle done is high → no result_valid pulse, all registers 0, and the next job's op_count starts from 0.

Source files
------------

// File: rtl/fsm_datapath.sv
// Execution datapath for the multi-cycle control FSM: operand muxes, ALU, X/S/H registers,
// status flags and a per-job load counter whose value is captured on done.
module fsm_datapath #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_in,
  input  logic [1:0]    m0,
  input  logic [1:0]    m1,
  input  logic [1:0]    m2,
  input  logic          lx,
  input  logic          ls,
  input  logic          lh,
  input  logic          h,
  input  logic          done,
  output logic [W-1:0]  x_q,
  output logic [W-1:0]  s_q,
  output logic [W-1:0]  h_q,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic [W-1:0]  result,
  output logic          result_valid,
  output logic [CW-1:0] op_count
);

  localparam logic [CW-1:0] CntMax = '1;

  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W:0]    alu;
  logic [W-1:0]  wv;
  logic          load;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    opa = x_q;
    unique case (m0)
      2'b00: opa = x_q;
      2'b01: opa = s_q;
      2'b10: opa = h_q;
      2'b11: opa = data_in;
      default: opa = x_q;
    endcase
  end

  always_comb begin
    opb = x_q;
    unique case (m1)
      2'b00: opb = x_q;
      2'b01: opb = s_q;
      2'b10: opb = h_q;
      2'b11: opb = W'(1);
      default: opb = x_q;
    endcase
  end

  // Bit W is carry for add/shl and borrow for sub (set exactly when A < B unsigned).
  always_comb begin
    alu = '0;
    unique case (m2)
      2'b00: alu = {1'b0, opa} + {1'b0, opb};
      2'b01: alu = {1'b0, opa} - {1'b0, opb};
      2'b10: alu = {1'b0, opa};
      2'b11: alu = {opa, 1'b0};
      default: alu = '0;
    endcase
  end

  assign wv   = h ? alu[W:1] : alu[W-1:0];
  assign load = lx | ls | lh;

  // Count including the current cycle, saturating at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (load && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      s_q          <= '0;
      h_q          <= '0;
      flag_z       <= 1'b0;
      flag_n       <= 1'b0;
      flag_c       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      op_count     <= '0;
      cnt_q        <= '0;
    end else begin
      if (lx) x_q <= wv;
      if (ls) s_q <= wv;
      if (lh) h_q <= wv;
      if (load) begin
        flag_z <= (wv == '0);
        flag_n <= wv[W-1];
        flag_c <= alu[W];
      end
      result_valid <= done;
      if (done) begin
        result   <= ls ? wv : s_q;
        op_count <= cnt_d;
        cnt_q    <= '0;
      end else begin
        cnt_q    <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_fsm_datapath.sv
// Directed self-checking bench for fsm_datapath: one task per scenario, inline comparisons.
module tb_fsm_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic [1:0]  m0, m1, m2;
  logic        lx, ls, lh, h, done;
  logic [7:0]  x_q, s_q, h_q, result;
  logic        flag_z, flag_n, flag_c, result_valid;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_datapath #(.W(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .m0(m0), .m1(m1), .m2(m2),
    .lx(lx), .ls(ls), .lh(lh), .h(h), .done(done),
    .x_q(x_q), .s_q(s_q), .h_q(h_q), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .result(result), .result_valid(result_valid), .op_count(op_count)
  );

  task automatic drive(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2,
                       input logic vx, input logic vs, input logic vh, input logic vhalf,
                       input logic vdone, input logic [7:0] din);
    m0 = a0; m1 = a1; m2 = a2; lx = vx; ls = vs; lh = vh; h = vhalf; done = vdone;
    data_in = din;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      step();
      n_checks++;
      if (result_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_rv: got %b want 0", result_valid);
      end
    end
    n_checks++;
    if ({x_q, s_q, h_q, result, op_count} !== '0) begin
      n_fail++; $display("FAIL rst_regs: got %h %h %h %h %h want all 0",
                         x_q, s_q, h_q, result, op_count);
    end
    n_checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags: got %b%b%b want 000", flag_z, flag_n, flag_c);
    end
    idle();
    rst = 1'b0;
    step();
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_rv: got %b want 0", result_valid);
    end
  endtask

  task automatic test_load_inc();
    drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'h05);
    step();
    n_checks++;
    if (x_q !== 8'h05 || flag_z !== 1'b0) begin
      n_fail++; $display("FAIL ld_x: got x=%h z=%b want x=05 z=0", x_q, flag_z);
    end
    drive(2'b00, 2'b11, 2'b00, 0, 1, 0, 0, 0, 8'h00);
    step();
    n_checks++;
    if (s_q !== 8'h06 || {flag_z, flag_n, flag_c} !== 3'b000) begin
      n_fail++; $display("FAIL inc_s: got s=%h znc=%b%b%b want s=06 znc=000",
                         s_q, flag_z, flag_n, flag_c);
    end
    // X-X+... with no load: flags and registers must hold.
    drive(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 8'h00);
    step();
    n_checks++;
    if (x_q !== 8'h05 || s_q !== 8'h06 || {flag_z, flag_n, flag_c} !== 3'b000) begin
      n_fail++; $display("FAIL hold: got x=%h s=%h znc=%b%b%b want x=05 s=06 znc=000",
                         x_q, s_q, flag_z, flag_n, flag_c);
    end
  endtask

  task automatic test_halved_add();
    drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'hFF); step();
    drive(2'b11, 2'b00, 2'b10, 0, 0, 1, 0, 0, 8'h01); step();
    drive(2'b00, 2'b10, 2'b00, 0, 0, 1, 1, 0, 8'h00); step();
    n_checks++;
    if (h_q !== 8'h80 || {flag_z, flag_n, flag_c} !== 3'b011) begin
      n_fail++; $display("FAIL half_add: got h=%h znc=%b%b%b want h=80 znc=011",
                         h_q, flag_z, flag_n, flag_c);
    end
  endtask

  task automatic test_borrow_shift();
    drive(2'b11, 2'b00, 2'b10, 0, 1, 0, 0, 0, 8'h06); step();
    drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'h07); step();
    drive(2'b01, 2'b00, 2'b01, 0, 1, 0, 0, 0, 8'h00); step();
    n_checks++;
    if (s_q !== 8'hFF || {flag_n, flag_c} !== 2'b11 || flag_z !== 1'b0) begin
      n_fail++; $display("FAIL borrow: got s=%h znc=%b%b%b want s=ff znc=011",
                         s_q, flag_z, flag_n, flag_c);
    end
    drive(2'b01, 2'b00, 2'b11, 0, 1, 0, 0, 0, 8'h00); step();
    n_checks++;
    if (s_q !== 8'hFE || {flag_z, flag_n, flag_c} !== 3'b011) begin
      n_fail++; $display("FAIL shl: got s=%h znc=%b%b%b want s=fe znc=011",
                         s_q, flag_z, flag_n, flag_c);
    end
    // X - X into H: zero with no borrow.
    drive(2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 8'h00); step();
    n_checks++;
    if (h_q !== 8'h00 || {flag_z, flag_n, flag_c} !== 3'b100) begin
      n_fail++; $display("FAIL sub_zero: got h=%h znc=%b%b%b want h=00 znc=100",
                         h_q, flag_z, flag_n, flag_c);
    end
  endtask

  task automatic test_done_same_cycle();
    // Close out whatever count earlier tests left behind.
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'h00); step();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'(i + 1)); step();
    end
    drive(2'b11, 2'b00, 2'b10, 0, 1, 0, 0, 1, 8'h2A); step();
    n_checks++;
    if (result !== 8'h2A || op_count !== 16'd4 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL done_ls: got res=%h cnt=%0d rv=%b want res=2a cnt=4 rv=1",
                         result, op_count, result_valid);
    end
    idle(); step();
    n_checks++;
    if (result_valid !== 1'b0 || result !== 8'h2A || op_count !== 16'd4) begin
      n_fail++; $display("FAIL done_hold: got res=%h cnt=%0d rv=%b want res=2a cnt=4 rv=0",
                         result, op_count, result_valid);
    end
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'h00); step();
    n_checks++;
    if (result_valid !== 1'b1 || op_count !== 16'd0 || result !== 8'h2A) begin
      n_fail++; $display("FAIL done_empty: got res=%h cnt=%0d rv=%b want res=2a cnt=0 rv=1",
                         result, op_count, result_valid);
    end
  endtask

  task automatic test_back_to_back();
    // done with an lx load (S unchanged, so result = S = 2a), then done again with no loads.
    drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 1, 8'h11); step();
    n_checks++;
    if (result_valid !== 1'b1 || op_count !== 16'd1 || result !== 8'h2A) begin
      n_fail++; $display("FAIL b2b_first: got res=%h cnt=%0d rv=%b want res=2a cnt=1 rv=1",
                         result, op_count, result_valid);
    end
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'h00); step();
    n_checks++;
    if (result_valid !== 1'b1 || op_count !== 16'd0) begin
      n_fail++; $display("FAIL b2b_second: got cnt=%0d rv=%b want cnt=0 rv=1",
                         op_count, result_valid);
    end
    idle(); step();
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got rv=%b want 0", result_valid);
    end
  endtask

  task automatic test_reset_mid_job();
    drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'h33); step();
    drive(2'b11, 2'b00, 2'b10, 0, 0, 1, 0, 0, 8'h44); step();
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b10, 0, 1, 0, 0, 1, 8'h55); step();
    n_checks++;
    if (result_valid !== 1'b0 || {x_q, s_q, h_q, result, op_count} !== '0) begin
      n_fail++; $display("FAIL mid_rst: got rv=%b x=%h s=%h h=%h res=%h cnt=%0d want all 0",
                         result_valid, x_q, s_q, h_q, result, op_count);
    end
    rst = 1'b0;
    idle(); step();
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_rv: got rv=%b want 0", result_valid);
    end
    drive(2'b11, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'h09); step();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'h00); step();
    n_checks++;
    if (result_valid !== 1'b1 || op_count !== 16'd1 || result !== 8'h00) begin
      n_fail++; $display("FAIL mid_rst_next: got res=%h cnt=%0d rv=%b want res=00 cnt=1 rv=1",
                         result, op_count, result_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_inc();
    test_halved_add();
    test_borrow_shift();
    test_done_same_cycle();
    test_back_to_back();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
